// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// -------------
// Shares one UART transmitter between NUM_REQ byte-stream requesters. The
// block is the only master on the UART register bus. Each byte is sent by
// polling STATUS until the transmitter is idle and then writing TX_DATA.
// Requesters are served round-robin. A granted requester keeps the
// transmitter until it sends a byte marked last, or until it leaves valid
// low for LOCK_TIMEOUT cycles. Baud-divider (CTRL) updates are queued and
// written only between packets, and only after STATUS shows the
// transmitter idle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/data/last      per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                one-hot byte accept, combinational
//   cfg_div, cfg_load        new divider, one-cycle load pulse
//   grant_id                 current or most recent granted requester
//   busy                     scheduler is not idle
//   uart_addr/wr_en/rd_en    UART register bus, master side
//   uart_wdata/rdata         (read data is returned in the cycle of rd_en)

module uart_tx_sched #(
    parameter int          NUM_REQ      = 4,
    parameter logic [15:0] DEFAULT_DIV  = 16'd867,
    parameter int          LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [15:0]                cfg_div,
    input  logic                       cfg_load,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [7:0]                 uart_addr,
    output logic                       uart_wr_en,
    output logic                       uart_rd_en,
    output logic [31:0]                uart_wdata,
    input  logic [31:0]                uart_rdata
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    localparam logic [7:0] ADDR_TX_DATA = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h08;
    localparam logic [7:0] ADDR_CTRL    = 8'h0C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_WRITE_CFG,
        S_WRITE_TX,
        S_WAIT_NEXT
    } state_t;

    state_t        state_q,   state_d;
    logic [GW-1:0] rr_ptr_q,  rr_ptr_d;
    logic [GW-1:0] grant_q,   grant_d;
    logic          cfg_pend_q, cfg_pend_d;
    logic [15:0]   cfg_val_q, cfg_val_d;
    logic          lock_q,    lock_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic          tgt_cfg_q, tgt_cfg_d;   // 1: the running POLL leads to a CTRL write

    logic          arb_hit;
    logic [GW-1:0] arb_idx;
    logic [GW-1:0] cand;
    logic          tx_valid;
    logic          tx_last;
    logic [7:0]    tx_byte;

    // Only STATUS bit 0 carries meaning for this block.
    logic unused_rdata;
    assign unused_rdata = ^uart_rdata[31:1];

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
        return (v == LAST_IDX) ? '0 : v + 1'b1;
    endfunction

    // Round-robin search. Candidates are visited from farthest to nearest
    // so that the last hit, which is the one kept, is the first valid
    // requester at or after rr_ptr.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = rr_ptr_q;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Select the stream of the granted requester.
    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_byte  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                tx_valid = req_valid[i];
                tx_last  = req_last[i];
                tx_byte  = req_data[8*i +: 8];
            end
        end
    end

    // NOTE: every signal assigned in this block gets a default before the
    // case statement, so no path leaves a value undriven and no latch is
    // inferred.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cfg_pend_d = cfg_pend_q;
        cfg_val_d  = cfg_val_q;
        lock_d     = lock_q;
        to_cnt_d   = to_cnt_q;
        tgt_cfg_d  = tgt_cfg_q;
        uart_addr  = 8'h00;
        uart_wr_en = 1'b0;
        uart_rd_en = 1'b0;
        uart_wdata = 32'h0;
        req_ready  = '0;

        case (state_q)
            S_IDLE: begin
                // A pending divider update is served before any new packet.
                if (cfg_pend_q && !lock_q) begin
                    tgt_cfg_d = 1'b1;
                    state_d   = S_POLL;
                end else if (arb_hit) begin
                    grant_d   = arb_idx;
                    tgt_cfg_d = 1'b0;
                    state_d   = S_POLL;
                end
            end

            S_POLL: begin
                uart_rd_en = 1'b1;
                uart_addr  = ADDR_STATUS;
                if (!uart_rdata[0]) begin
                    state_d = tgt_cfg_q ? S_WRITE_CFG : S_WRITE_TX;
                end
            end

            S_WRITE_CFG: begin
                uart_wr_en = 1'b1;
                uart_addr  = ADDR_CTRL;
                uart_wdata = {16'h0000, cfg_val_q};
                cfg_pend_d = 1'b0;
                state_d    = S_IDLE;
            end

            S_WRITE_TX: begin
                uart_wr_en = 1'b1;
                uart_addr  = ADDR_TX_DATA;
                uart_wdata = {24'h000000, tx_byte};
                req_ready  = NUM_REQ'(1) << grant_q;
                if (tx_last) begin
                    lock_d   = 1'b0;
                    rr_ptr_d = wrap_inc(grant_q);
                    state_d  = S_IDLE;
                end else begin
                    lock_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_NEXT;
                end
            end

            S_WAIT_NEXT: begin
                // Only the locked requester is watched here; everyone else,
                // including a pending CTRL update, waits for the packet end.
                if (tx_valid) begin
                    tgt_cfg_d = 1'b0;
                    state_d   = S_POLL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (LOCK_TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = wrap_inc(grant_q);
                        state_d  = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A load pulse is captured in every state; when it coincides with
        // the CTRL write it re-arms the update with the newer value.
        if (cfg_load) begin
            cfg_pend_d = 1'b1;
            cfg_val_d  = cfg_div;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge, independent of the
    // order in which the simulator evaluates the processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cfg_pend_q <= 1'b1;
            cfg_val_q  <= DEFAULT_DIV;
            lock_q     <= 1'b0;
            to_cnt_q   <= '0;
            tgt_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_val_q  <= cfg_val_d;
            lock_q     <= lock_d;
            to_cnt_q   <= to_cnt_d;
            tgt_cfg_q  <= tgt_cfg_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched. A small UART model answers STATUS reads and
// holds TX busy for 10*(div+1) cycles after each TX_DATA write. The stimulus
// issues packets and pushes the expected UART writes, in round-robin order,
// into a scoreboard queue. A monitor pops an entry for every write the DUT
// makes and also checks the bus rules on every cycle.

module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int GW = 2;
    localparam int LT = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [15:0]      cfg_div;
    logic             cfg_load;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic [7:0]       uart_addr;
    logic             uart_wr_en;
    logic             uart_rd_en;
    logic [31:0]      uart_wdata;
    logic [31:0]      uart_rdata;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .DEFAULT_DIV (16'd867),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .cfg_div   (cfg_div),
        .cfg_load  (cfg_load),
        .grant_id  (grant_id),
        .busy      (busy),
        .uart_addr (uart_addr),
        .uart_wr_en(uart_wr_en),
        .uart_rd_en(uart_rd_en),
        .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- UART model ----------------
    int unsigned uart_busy_cnt = 0;
    logic [15:0] uart_div      = 16'd0;

    assign uart_rdata = {31'b0, uart_busy_cnt != 0};

    always @(posedge clk) begin
        if (uart_busy_cnt != 0) uart_busy_cnt <= uart_busy_cnt - 1;
        if (uart_wr_en) begin
            if (uart_addr == 8'h00)      uart_busy_cnt <= 10 * (int'(uart_div) + 1);
            else if (uart_addr == 8'h0C) uart_div      <= uart_wdata[15:0];
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [2:0]  gid;
        logic        is_tx;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   rr_m = 0;   // reference round-robin pointer

    task automatic push_ctrl(input logic [15:0] div);
        sb_q.push_back('{addr: 8'h0C, data: {16'h0, div}, gid: 3'd0, is_tx: 1'b0});
    endtask

    task automatic push_tx(input int gid, input logic [7:0] b);
        sb_q.push_back('{addr: 8'h00, data: {24'h0, b}, gid: 3'(gid), is_tx: 1'b1});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_exclusive", 32'(uart_wr_en & uart_rd_en), 32'd0);
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (!uart_wr_en) check("wdata_zero_when_idle", uart_wdata, 32'd0);
            if (uart_rd_en)  check("poll_addr", 32'(uart_addr), 32'h08);
            if (req_ready != '0) check("ready_only_in_tx_write", 32'(uart_wr_en && uart_addr == 8'h00), 32'd1);
            if (uart_wr_en) begin
                check("write_while_uart_idle", 32'(uart_rdata[0]), 32'd0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", uart_addr, uart_wdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("write_addr", 32'(uart_addr), 32'(mon_e.addr));
                    check("write_data", uart_wdata, mon_e.data);
                    if (mon_e.is_tx) begin
                        check("grant_id", 32'(grant_id), 32'(mon_e.gid));
                        check("req_ready", 32'(req_ready), 32'd1 << mon_e.gid);
                    end
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    logic [7:0] pkt_bytes [N][4];
    int         pkt_len   [N];
    bit         pkt_nolast[N];
    int         go_seq    [N];
    int         abort_seq = 0;

    logic [N-1:0] drv_v = '0;
    logic [N-1:0] drv_l = '0;
    logic [7:0]   drv_d [N];
    logic [N-1:0] rdy_s;
    int           done_seq[N];
    int           seen_seq[N];
    int           pos     [N];
    int           gap_left[N];
    bit           act     [N];
    int           abort_seen = 0;

    assign req_valid = drv_v;
    assign req_last  = drv_l;
    always_comb begin
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = drv_d[i];
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            drv_d[i] = 8'h00; done_seq[i] = 0; seen_seq[i] = 0;
            pos[i] = 0; gap_left[i] = 0; act[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            @(posedge clk);
            #1;
            if (abort_seq != abort_seen) begin
                abort_seen = abort_seq;
                for (int i = 0; i < N; i++) begin
                    act[i] = 1'b0; drv_v[i] = 1'b0; drv_l[i] = 1'b0;
                    seen_seq[i] = go_seq[i]; done_seq[i] = go_seq[i];
                end
                rdy_s = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (rdy_s[i] && drv_v[i]) begin
                    drv_v[i]    = 1'b0;
                    pos[i]      = pos[i] + 1;
                    gap_left[i] = $urandom_range(0, 3);
                    if (pos[i] == pkt_len[i]) begin
                        act[i]      = 1'b0;
                        done_seq[i] = seen_seq[i];
                    end
                end
                if (!act[i] && go_seq[i] != seen_seq[i]) begin
                    seen_seq[i] = go_seq[i];
                    act[i] = 1'b1; pos[i] = 0; gap_left[i] = 0;
                end
                if (act[i] && !drv_v[i]) begin
                    if (gap_left[i] == 0) begin
                        drv_d[i] = pkt_bytes[i][pos[i]];
                        drv_l[i] = (pos[i] == pkt_len[i] - 1) && !pkt_nolast[i];
                        drv_v[i] = 1'b1;
                    end else begin
                        gap_left[i] = gap_left[i] - 1;
                    end
                end
            end
        end
    end

    // Reference model: packets that are all present at once are served in
    // cyclic order starting at the pointer; each finished (or timed-out)
    // packet moves the pointer just past its owner. An optional CTRL update
    // raised during the first packet lands right after that packet.
    task automatic start_round(input logic [N-1:0] mask, input bit cfg_mid, input logic [15:0] mid_div);
        int base;
        bit first;
        base  = rr_m;
        first = 1'b1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (base + k) % N;
            if (mask[i]) begin
                for (int b = 0; b < pkt_len[i]; b++) push_tx(i, pkt_bytes[i][b]);
                rr_m = (i + 1) % N;
                if (first && cfg_mid) push_ctrl(mid_div);
                first = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) if (mask[i]) go_seq[i] = go_seq[i] + 1;
    endtask

    task automatic set_pkt(input int i, input int len, input logic [31:0] bytes, input bit nolast);
        logic [31:0] bv;
        bv = bytes;
        pkt_len[i]    = len;
        pkt_nolast[i] = nolast;
        for (int b = 0; b < 4; b++) pkt_bytes[i][b] = bv[8*b +: 8];
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy && done_seq == go_seq) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: scheduler not idle after 20000 cycles, %0d writes outstanding", tag, sb_q.size());
            finish_test();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cfg(input logic [15:0] div);
        cfg_div  = div;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_wr_en"},     32'(uart_wr_en), 32'd0);
        check({tag, "_rd_en"},     32'(uart_rd_en), 32'd0);
        check({tag, "_addr"},      32'(uart_addr),  32'd0);
        check({tag, "_wdata"},     uart_wdata,      32'd0);
        check({tag, "_req_ready"}, 32'(req_ready),  32'd0);
        check({tag, "_grant_id"},  32'(grant_id),   32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        finish_test();
    end

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        int          cnt;
        bit          seen;
        logic [N-1:0] mask;

        for (int i = 0; i < N; i++) begin
            go_seq[i] = 0; pkt_len[i] = 1; pkt_nolast[i] = 1'b0;
            for (int b = 0; b < 4; b++) pkt_bytes[i][b] = 8'h00;
        end
        rst      = 1'b1;
        cfg_load = 1'b0;
        cfg_div  = 16'h0000;

        // Reset state and the post-reset CTRL write of the default divider.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        push_ctrl(16'd867);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("post_reset_ctrl");

        // Divider 3, then a single byte with the valid-to-ready latency.
        pulse_cfg(16'd3);
        push_ctrl(16'd3);
        wait_idle("cfg_div3");
        set_pkt(0, 1, 32'h000000A5, 1'b0);
        start_round(4'b0001, 1'b0, 16'h0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_valid[0]) begin seen = 1'b1; break; end
        end
        lat = 1;
        for (int t = 0; t < 20 && !req_ready[0]; t++) begin
            @(negedge clk);
            lat++;
        end
        check("valid_to_ready_latency", 32'(lat), 32'd3);
        check("latency_valid_seen", 32'(seen), 32'd1);
        wait_idle("single_byte");

        // Two contenders, then a contest decided by the moved pointer.
        set_pkt(1, 1, 32'h00000011, 1'b0);
        set_pkt(2, 1, 32'h00000022, 1'b0);
        start_round(4'b0110, 1'b0, 16'h0);
        wait_idle("rr_round_a");
        set_pkt(1, 1, 32'h00000044, 1'b0);
        set_pkt(3, 1, 32'h00000033, 1'b0);
        start_round(4'b1010, 1'b0, 16'h0);
        wait_idle("rr_round_b");

        // Locked 3-byte packet against a waiting requester, with a divider
        // update raised during the second byte.
        set_pkt(0, 3, 32'h00030201, 1'b0);
        set_pkt(1, 1, 32'h00000099, 1'b0);
        start_round(4'b0011, 1'b1, 16'h0010);
        seen = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (req_ready[0] && req_data[7:0] == 8'h02) begin seen = 1'b1; break; end
        end
        check("second_byte_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        pulse_cfg(16'h0010);
        wait_idle("locked_packet_cfg");

        // Lock timeout: requester 2 stops after a non-last byte.
        set_pkt(2, 1, 32'h00000077, 1'b1);
        set_pkt(3, 1, 32'h00000033, 1'b0);
        start_round(4'b1100, 1'b0, 16'h0);
        seen = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (req_ready[2]) begin seen = 1'b1; break; end
        end
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        check("lock_timeout_cycles", 32'(cnt), 32'(LT));
        check("timeout_byte_seen", 32'(seen), 32'd1);
        wait_idle("timeout");

        // Randomised rounds.
        for (int r = 0; r < 10; r++) begin
            if (r == 0 || $urandom_range(0, 1) == 1) begin
                logic [15:0] d;
                d = 16'($urandom_range(1, 4));
                pulse_cfg(d);
                push_ctrl(d);
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                set_pkt(i, $urandom_range(1, 4), $urandom, ($urandom_range(0, 5) == 0));
            end
            start_round(mask, 1'b0, 16'h0);
            wait_idle("random_round");
        end

        // Reset while polling a busy UART.
        set_pkt(0, 1, 32'h0000005A, 1'b0);
        start_round(4'b0001, 1'b0, 16'h0);
        wait_idle("pre_abort_byte");
        set_pkt(1, 1, 32'h00000066, 1'b0);
        go_seq[1] = go_seq[1] + 1;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (uart_rd_en) begin seen = 1'b1; break; end
        end
        check("poll_before_abort", 32'(seen), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        abort_seq = abort_seq + 1;
        sb_q.delete();
        rr_m = 0;
        push_ctrl(16'd867);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("post_abort_ctrl");

        finish_test();
    end

endmodule
